int_to_float: RTL and testbench

INT_TO_FLOAT -- requirements
Module: int_to_float

---
 rtl/int_to_float.sv | 158 +++++++++++++++
 tb/tb_int_to_float.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/int_to_float.sv
// Converts a 32-bit two's-complement integer to IEEE-754 single precision over a valid/ack handshake.
// Define I2F_ROUND_NEAREST_EN for round-to-nearest-even; otherwise the result is truncated toward zero.
module int_to_float (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [2:0] {
    GET_A,
    CONVERT_0,
    NORMALISE,
    CONVERT_1,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

  state_t      r_state, w_state;
  logic        r_input_a_ack, w_input_a_ack;
  logic        r_output_z_stb, w_output_z_stb;
  logic [31:0] r_output_z, w_output_z;

  logic [31:0] r_a, w_a;
  logic [31:0] r_value, w_value;
  logic [7:0]  r_z_e, w_z_e;
  logic [23:0] r_z_m, w_z_m;
  logic        r_z_s, w_z_s;
  logic        r_guard, w_guard;
  logic        r_round_bit, w_round_bit;
  logic        r_sticky, w_sticky;
  logic [31:0] r_z, w_z;

  logic [31:0] w_abs;

  // 0x80000000 negates to itself, which is already the correct magnitude.
  assign w_abs = r_a[31] ? (~r_a + 32'd1) : r_a;

  // NOTE: every next-state value gets its default first, so no path through the case can infer a latch.
  always_comb begin
    w_state        = r_state;
    w_input_a_ack  = r_input_a_ack;
    w_output_z_stb = r_output_z_stb;
    w_output_z     = r_output_z;
    w_a            = r_a;
    w_value        = r_value;
    w_z_e          = r_z_e;
    w_z_m          = r_z_m;
    w_z_s          = r_z_s;
    w_guard        = r_guard;
    w_round_bit    = r_round_bit;
    w_sticky       = r_sticky;
    w_z            = r_z;

    case (r_state)
      GET_A: begin
        w_input_a_ack = 1'b1;
        if (r_input_a_ack && input_a_stb) begin
          w_a           = input_a;
          w_input_a_ack = 1'b0;
          w_state       = CONVERT_0;
        end
      end
      CONVERT_0: begin
        if (r_a == 32'd0) begin
          w_z     = 32'd0;
          w_state = PUT_Z;
        end else begin
          w_z_s   = r_a[31];
          w_value = w_abs;
          w_z_e   = 8'd31;
          w_state = NORMALISE;
        end
      end
      NORMALISE: begin
        if (!r_value[31]) begin
          w_value = r_value << 1;
          w_z_e   = r_z_e - 8'd1;
        end else begin
          w_state = CONVERT_1;
        end
      end
      CONVERT_1: begin
        w_z_m       = r_value[31:8];
        w_guard     = r_value[7];
        w_round_bit = r_value[6];
        w_sticky    = |r_value[5:0];
        w_state     = ROUND;
      end
      ROUND: begin
`ifdef I2F_ROUND_NEAREST_EN
        if (r_guard && (r_round_bit || r_sticky || r_z_m[0])) begin
          w_z_m = r_z_m + 24'd1;
          if (r_z_m == 24'hFF_FFFF) w_z_e = r_z_e + 8'd1;
        end
`endif
        w_state = PACK;
      end
      PACK: begin
        w_z     = {r_z_s, r_z_e + 8'd127, r_z_m[22:0]};
        w_state = PUT_Z;
      end
      PUT_Z: begin
        w_output_z_stb = 1'b1;
        w_output_z     = r_z;
        if (r_output_z_stb && output_z_ack) begin
          w_output_z_stb = 1'b0;
          w_state        = GET_A;
        end
      end
      default: w_state = GET_A;
    endcase
  end

`ifndef I2F_ROUND_NEAREST_EN
  // Truncation never looks at the rounding bits or the hidden bit.
  logic w_unused_round;
  assign w_unused_round = ^{r_guard, r_round_bit, r_sticky, r_z_m[23]};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= GET_A;
      r_input_a_ack  <= 1'b0;
      r_output_z_stb <= 1'b0;
      r_output_z     <= 32'd0;
    end else begin
      r_state        <= w_state;
      r_input_a_ack  <= w_input_a_ack;
      r_output_z_stb <= w_output_z_stb;
      r_output_z     <= w_output_z;
    end
  end

  // NOTE: datapath registers are left unreset; the FSM always writes them before they are read.
  always_ff @(posedge clk) begin
    r_a         <= w_a;
    r_value     <= w_value;
    r_z_e       <= w_z_e;
    r_z_m       <= w_z_m;
    r_z_s       <= w_z_s;
    r_guard     <= w_guard;
    r_round_bit <= w_round_bit;
    r_sticky    <= w_sticky;
    r_z         <= w_z;
  end

  assign input_a_ack  = r_input_a_ack;
  assign output_z_stb = r_output_z_stb;
  assign output_z     = r_output_z;

endmodule

// File: tb/tb_int_to_float.sv
// Directed bench for int_to_float: scoreboard of expected floats, latency, handshake and reset checks.
// Expected values follow the I2F_ROUND_NEAREST_EN setting of the build.
module tb_int_to_float;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb_q[$];

  int_to_float dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference conversion through the exact double-precision value of the integer.
  function automatic logic [31:0] model(input logic [31:0] a);
    logic [63:0] d;
    logic [23:0] m;
    int          e;
    logic        g;
    logic        rest;
    if (a == 32'd0) return 32'd0;
    d    = $realtobits($itor($signed(a)));
    e    = int'(d[62:52]) - 1023 + 127;
    m    = {1'b1, d[51:29]};
    g    = d[28];
    rest = |d[27:0];
`ifdef I2F_ROUND_NEAREST_EN
    if (g && (rest || m[0])) begin
      m = m + 24'd1;
      if (m == 24'd0) e = e + 1;
    end
`else
    if (g && rest) m = m;
`endif
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic int exp_latency(input logic [31:0] a);
    logic [31:0] mag;
    int          lz;
    if (a == 32'd0) return 2;
    mag = a[31] ? (~a + 32'd1) : a;
    lz  = 0;
    for (int i = 31; i >= 0; i--) begin
      if (mag[i]) break;
      lz++;
    end
    return lz + 6;
  endfunction

  task automatic wait_ack(input string tag);
    int n = 0;
    while (!input_a_ack && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_ack_ready"}, {31'd0, input_a_ack}, 32'd1);
  endtask

  // One operand end-to-end: capture, latency, value, hold for hold_cycles, handshake.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] exp,
                        input int hold_cycles, input bit keep_stb);
    int          cycles;
    logic [31:0] want;
    wait_ack(tag);
    input_a     = a;
    input_a_stb = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    if (keep_stb) input_a = 32'hDEAD_BEEF;
    else          input_a_stb = 1'b0;
    cycles = 0;
    while (!output_z_stb && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      if (!output_z_stb)
        check({tag, "_no_overlap_busy"}, {31'd0, input_a_ack}, 32'd0);
    end
    input_a_stb = 1'b0;
    check({tag, "_stb"}, {31'd0, output_z_stb}, 32'd1);
    check({tag, "_latency"}, cycles, exp_latency(a));
    check({tag, "_ack_low_at_stb"}, {31'd0, input_a_ack}, 32'd0);
    want = sb_q.pop_front();
    check({tag, "_value"}, output_z, want);
    for (int i = 0; i < hold_cycles; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_stb"}, {31'd0, output_z_stb}, 32'd1);
      check({tag, "_hold_value"}, output_z, want);
      check({tag, "_hold_ack"}, {31'd0, input_a_ack}, 32'd0);
    end
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    check({tag, "_stb_drop"}, {31'd0, output_z_stb}, 32'd0);
    check({tag, "_value_after"}, output_z, want);
    check({tag, "_ack_not_yet"}, {31'd0, input_a_ack}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_ack_rise"}, {31'd0, input_a_ack}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    rst          = 1'b1;
    input_a      = 32'd0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", {31'd0, input_a_ack}, 32'd0);
    check("reset_stb", {31'd0, output_z_stb}, 32'd0);
    check("reset_z", output_z, 32'd0);
    // Consumer ack while nothing is pending must be harmless.
    output_z_ack = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    check("first_ack_rise", {31'd0, input_a_ack}, 32'd1);
    check("idle_stb", {31'd0, output_z_stb}, 32'd0);

    run_op("one",      32'h0000_0001, 32'h3F80_0000, 0, 1'b0);
    run_op("minus1",   32'hFFFF_FFFF, 32'hBF80_0000, 0, 1'b0);
    run_op("intmin",   32'h8000_0000, 32'hCF00_0000, 0, 1'b0);
    run_op("zero",     32'h0000_0000, 32'h0000_0000, 0, 1'b0);
`ifdef I2F_ROUND_NEAREST_EN
    run_op("intmax",   32'h7FFF_FFFF, 32'h4F00_0000, 0, 1'b0);
    run_op("rnd_up",   32'h0100_0003, 32'h4B80_0002, 0, 1'b0);
`else
    run_op("intmax",   32'h7FFF_FFFF, 32'h4EFF_FFFF, 0, 1'b0);
    run_op("rnd_up",   32'h0100_0003, 32'h4B80_0001, 0, 1'b0);
`endif
    run_op("tie_even", 32'h0100_0001, 32'h4B80_0000, 0, 1'b0);
    run_op("backpres", 32'h1234_5678, model(32'h1234_5678), 10, 1'b0);
    run_op("stb_busy", 32'hFFFF_FF01, model(32'hFFFF_FF01), 0, 1'b1);
    run_op("24bit",    32'h00FF_FFFF, model(32'h00FF_FFFF), 0, 1'b0);
    run_op("tie_odd",  32'h0300_0001, model(32'h0300_0001), 0, 1'b0);
    run_op("near_min", 32'h8000_0001, model(32'h8000_0001), 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      r = $urandom;
      run_op("random", r, model(r), 0, 1'b0);
    end

    // Reset in the middle of normalising 1: the operand is abandoned.
    wait_ack("abandon");
    input_a     = 32'h0000_0001;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_ack", {31'd0, input_a_ack}, 32'd0);
    check("mid_rst_z", output_z, 32'd0);
    @(posedge clk); #1;
    check("post_rst_ack", {31'd0, input_a_ack}, 32'd1);
    begin
      int seen = 0;
      for (int i = 0; i < 45; i++) begin
        if (output_z_stb) seen++;
        @(posedge clk); #1;
      end
      check("abandon_no_stb", seen, 0);
    end
    check("abandon_z", output_z, 32'd0);
    run_op("after_rst", 32'h0000_0002, 32'h4000_0000, 0, 1'b0);
    check("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
